// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the unified-memory arbiter.
package mem_arb_pkg;

    // Owner tag carried alongside each read in flight.
    localparam logic [0:0] MEM_ARB_OWNER_IF = 1'b0;
    localparam logic [0:0] MEM_ARB_OWNER_D  = 1'b1;

    // Priority FSM state encodings.
    localparam logic [0:0] D_PRI  = 1'b0;
    localparam logic [0:0] IF_PRI = 1'b1;

    // Default memory read latency and fetch starvation limit.
    localparam int DEF_MEM_LAT    = 1;
    localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/mem_arb_tagpipe.sv
// MEM_LAT-deep shift register of {valid, owner} tags that tracks reads in
// flight so returning data can be steered back to the requester.
module mem_arb_tagpipe
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_valid_i,
    input  logic [0:0] push_owner_i,
    output logic       pop_valid_o,
    output logic [0:0] pop_owner_o
);

    logic [MEM_LAT-1:0] vld_q, vld_d;
    logic [MEM_LAT-1:0] own_q, own_d;

    // Shift every tag one stage toward the output each cycle.
    always_comb begin
        vld_d    = vld_q;
        own_d    = own_q;
        vld_d[0] = push_valid_i;
        own_d[0] = push_owner_i[0];
        for (int i = 1; i < MEM_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            own_d[i] = own_q[i-1];
        end
    end

    // Tag registers; reset discards anything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            own_q <= '0;
        end else begin
            vld_q <= vld_d;
            own_q <= own_d;
        end
    end

    assign pop_valid_o = vld_q[MEM_LAT-1];
    assign pop_owner_o = own_q[MEM_LAT-1];

endmodule

// File: rtl/mem_arb.sv
// Single-port memory arbiter between instruction fetch and the memory stage.
// Data normally wins; a fetch denied STARVE_MAX times in a row gets one turn
// at priority.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_stall_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_stall_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    input  logic              mem_ready_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [0:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       act;
    logic       if_win;
    logic       pop_valid;
    logic [0:0] pop_owner;

    // Grant selection and memory port mux; nothing is issued in reset or
    // while the memory is busy.
    always_comb begin
        act        = ~rst_i & mem_ready_i;
        if_win     = if_req_i & (~d_req_i | (state_q == IF_PRI));
        if_gnt_o   = act & if_win;
        d_gnt_o    = act & d_req_i & ~if_win;
        if_stall_o = ~rst_i & if_req_i & ~if_gnt_o;
        d_stall_o  = ~rst_i & d_req_i & ~d_gnt_o;
        mem_req_o  = if_gnt_o | d_gnt_o;
        mem_we_o   = d_gnt_o & d_we_i;
        mem_addr_o = '0;
        mem_wdata_o = '0;
        if (if_gnt_o) begin
            mem_addr_o = if_addr_i;
        end else if (d_gnt_o) begin
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end
    end

    // Starve counter and priority FSM; both freeze while memory is busy.
    // Going to IF_PRI on the counter's next value lets fetch win the cycle
    // right after the denial that reached the limit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (mem_ready_i) begin
            if (!if_req_i || if_gnt_o) begin
                cnt_d = 4'd0;
            end else if (cnt_q < STARVE_LIM) begin
                cnt_d = cnt_q + 4'd1;
            end
            if (state_q == D_PRI) begin
                if (cnt_d == STARVE_LIM) begin
                    state_d = IF_PRI;
                end
            end else if (if_gnt_o || !if_req_i) begin
                state_d = D_PRI;
            end
        end
    end

    // FSM and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= D_PRI;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    mem_arb_tagpipe #(
        .MEM_LAT (MEM_LAT)
    ) u_tagpipe (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_valid_i (mem_req_o & ~mem_we_o),
        .push_owner_i (d_gnt_o ? MEM_ARB_OWNER_D : MEM_ARB_OWNER_IF),
        .pop_valid_o  (pop_valid),
        .pop_owner_o  (pop_owner)
    );

    // Response steering; read data is passed straight through.
    always_comb begin
        if_rvalid_o = ~rst_i & pop_valid & (pop_owner == MEM_ARB_OWNER_IF);
        d_rvalid_o  = ~rst_i & pop_valid & (pop_owner == MEM_ARB_OWNER_D);
        if_rdata_o  = mem_rdata_i;
        d_rdata_o   = mem_rdata_i;
    end

endmodule
